perip_pump_ctrl: RTL

Memory-mapped irrigation pump controller on the FemtoRV32 SOC bus, in chip-select slot 3 (0x00430000). Firmware reads the soil/tank level from the ultrasonic peripheral and writes a run request here. The block then drives the pump relay for a programmed number of seconds and enforces a minimum off (cool-down) time between runs. It also provides optional dry-run protection from a tank-low input.

---
 rtl/perip_pump_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/perip_pump_ctrl.sv
// Memory-mapped irrigation pump controller: timed runs, enforced cool-down, tank-low sync.
// Optional dry-run protection is enabled by defining PUMP_DRYRUN_EN.
module perip_pump_ctrl #(
    parameter int unsigned CLK_FREQ = 25000000,
    parameter int unsigned MAX_RUN  = 600
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    input  logic        tank_low,
    output logic        pump
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
    localparam logic [15:0] MAX16 = 16'(MAX_RUN);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_RUNTIME = 3'd1;
    localparam logic [2:0] A_MINOFF  = 3'd2;
    localparam logic [2:0] A_STATUS  = 3'd3;
    localparam logic [2:0] A_REMAIN  = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COOLDOWN = 2'd2,
        FAULT    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   run_time_q, run_time_d;
    logic [15:0]   min_off_q, min_off_d;
    logic [15:0]   remain_q, remain_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          rejected_q, rejected_d;
    logic          fault_q, fault_d;
    logic          pump_q, pump_d;
    logic [31:0]   d_out_q, d_out_d;
    logic          tl_meta_q, tl_sync_q;

    logic [2:0]    sel;
    logic          wr_en, rd_en;
    logic          start, stop, clear, tick;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign unused_bits = ^{addr[31:5], addr[1:0], d_in[31:16]};

    assign sel   = addr[4:2];
    assign wr_en = cs & wr;
    assign rd_en = cs & rd;
    // STOP dominates START within one CTRL write.
    assign start = wr_en && (sel == A_CTRL) && d_in[0] && !d_in[1];
    assign stop  = wr_en && (sel == A_CTRL) && d_in[1];
    assign clear = wr_en && (sel == A_CTRL) && d_in[2];
    assign tick  = (presc_q == PRESC_LAST);

    function automatic logic [15:0] clamp(input logic [15:0] v);
        return (v > MAX16) ? MAX16 : v;
    endfunction

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        rejected_d = rejected_q;
        run_time_d = run_time_q;
        min_off_d  = min_off_q;

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef PUMP_DRYRUN_EN
                    if (tl_sync_q) begin
                        state_d  = FAULT;
                        remain_d = '0;
                    end else
`endif
                    if (run_time_q != '0) begin
                        state_d  = RUN;
                        remain_d = run_time_q;
                    end else begin
                        rejected_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // A fault outranks both STOP and the final tick.
`ifdef PUMP_DRYRUN_EN
                if (tl_sync_q) begin
                    state_d  = FAULT;
                    remain_d = '0;
                end else
`endif
                if (stop || (tick && remain_q <= 16'd1)) begin
                    if (min_off_q != '0) begin
                        state_d  = COOLDOWN;
                        remain_d = min_off_q;
                    end else begin
                        state_d  = IDLE;
                        remain_d = '0;
                    end
                end else if (tick) begin
                    remain_d = remain_q - 16'd1;
                end
            end
            COOLDOWN: begin
                if (start) begin
                    rejected_d = 1'b1;
                end
                if (tick) begin
                    if (remain_q <= 16'd1) begin
                        state_d  = IDLE;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - 16'd1;
                    end
                end
            end
            FAULT: begin
                if (clear && !tl_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            rejected_d = 1'b0;
        end

        if (wr_en && sel == A_RUNTIME) begin
            run_time_d = clamp(d_in[15:0]);
        end
        if (wr_en && sel == A_MINOFF) begin
            min_off_d = clamp(d_in[15:0]);
        end
    end

    always_comb begin
        pump_d = (state_d == RUN);
`ifdef PUMP_DRYRUN_EN
        fault_d = (state_d == FAULT);
`else
        fault_d = 1'b0;
`endif
        presc_d = (state_d != state_q || tick) ? '0 : presc_q + PW'(1);

        rdata = '0;
        case (sel)
            A_RUNTIME: rdata = {16'b0, run_time_q};
            A_MINOFF:  rdata = {16'b0, min_off_q};
            A_STATUS:  rdata = {26'b0, tl_sync_q, rejected_q, fault_q, pump_q, state_q};
            A_REMAIN:  rdata = {16'b0, remain_q};
            default:   rdata = '0;
        endcase
        d_out_d = rd_en ? rdata : d_out_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            run_time_q <= '0;
            min_off_q  <= '0;
            remain_q   <= '0;
            presc_q    <= '0;
            rejected_q <= 1'b0;
            fault_q    <= 1'b0;
            pump_q     <= 1'b0;
            d_out_q    <= '0;
            tl_meta_q  <= 1'b0;
            tl_sync_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_time_q <= run_time_d;
            min_off_q  <= min_off_d;
            remain_q   <= remain_d;
            presc_q    <= presc_d;
            rejected_q <= rejected_d;
            fault_q    <= fault_d;
            pump_q     <= pump_d;
            d_out_q    <= d_out_d;
            tl_meta_q  <= tank_low;
            tl_sync_q  <= tl_meta_q;
        end
    end

    assign pump  = pump_q;
    assign d_out = d_out_q;

endmodule
